// File: rtl/top_ej4_pkg.sv
// rtl/top_ej4_pkg.sv - shared sizing for the top_ej4 IIR filter
package top_ej4_pkg;

  localparam int NB_DATA_DEF = 8;
  // Guard bits that let the six-term sum be formed without intermediate overflow.
  localparam int NB_GUARD    = 3;

endpackage

// File: rtl/top_ej4_delay_line.sv
// rtl/top_ej4_delay_line.sv - shift-register delay line with synchronous clear
module delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [DEPTH*WIDTH-1:0]   taps
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // taps[WIDTH-1:0] is the most recent sample (n-1).
  for (genvar g = 0; g < DEPTH; g++) begin : g_tap
    assign taps[g*WIDTH +: WIDTH] = stage[g];
  end

endmodule

// File: rtl/top_ej4.sv
// rtl/top_ej4.sv - 8-bit signed IIR: y = x - x1 + x2 + x3 + y1/2 + y2/4, zero latency
module top_ej4
  import top_ej4_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
) (
  input  logic                      clock,
  input  logic                      i_rst_n,
  input  logic signed [NB_DATA-1:0] i_x,
  output logic signed [NB_DATA-1:0] o_y
);

  localparam int NB_SUM = NB_DATA + NB_GUARD;

  logic [3*NB_DATA-1:0] x_taps;
  logic [2*NB_DATA-1:0] y_taps;

  logic signed [NB_DATA-1:0] r_xm1, r_xm2, r_xm3;
  logic signed [NB_DATA-1:0] r_ym1, r_ym2;
  logic signed [NB_SUM-1:0]  sum;

  delay_line #(.DEPTH(3), .WIDTH(NB_DATA)) u_x_line (
    .clock (clock),
    .clear (i_rst_n),
    .din   (i_x),
    .taps  (x_taps)
  );

  // Feedback stores the wrapped output, not the wide sum.
  delay_line #(.DEPTH(2), .WIDTH(NB_DATA)) u_y_line (
    .clock (clock),
    .clear (i_rst_n),
    .din   (o_y),
    .taps  (y_taps)
  );

  assign r_xm1 = x_taps[0*NB_DATA +: NB_DATA];
  assign r_xm2 = x_taps[1*NB_DATA +: NB_DATA];
  assign r_xm3 = x_taps[2*NB_DATA +: NB_DATA];
  assign r_ym1 = y_taps[0*NB_DATA +: NB_DATA];
  assign r_ym2 = y_taps[1*NB_DATA +: NB_DATA];

  always_comb begin
    sum = NB_SUM'(i_x) - NB_SUM'(r_xm1) + NB_SUM'(r_xm2) + NB_SUM'(r_xm3)
        + NB_SUM'(r_ym1 >>> 1) + NB_SUM'(r_ym2 >>> 2);
  end

  assign o_y = sum[NB_DATA-1:0];

endmodule

// File: tb/tb_top_ej4.sv
// tb/tb_top_ej4.sv - scoreboard bench for top_ej4 against an integer reference model
module tb_top_ej4;

  logic              clock = 1'b0;
  logic              i_rst_n;
  logic signed [7:0] i_x;
  logic signed [7:0] o_y;

  int total = 0;
  int bad   = 0;

  int    exp_q [$];
  string name_q[$];

  int mx [3];
  int my [2];
  bit mvalid = 1'b0;

  top_ej4 dut (
    .clock   (clock),
    .i_rst_n (i_rst_n),
    .i_x     (i_x),
    .o_y     (o_y)
  );

  always #5 clock = ~clock;

  function automatic int wrap8(int v);
    int r;
    r = v % 256;
    if (r < 0) r += 256;
    if (r >= 128) r -= 256;
    return r;
  endfunction

  function automatic int floordiv(int v, int d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int model_out(int x);
    return wrap8(x - mx[0] + mx[1] + mx[2] + floordiv(my[0], 2) + floordiv(my[1], 4));
  endfunction

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Drive one sample; the expected output for this cycle goes to the scoreboard,
  // then the model advances to the state the next rising edge will produce.
  task automatic drive(int x, bit rst, bit use_fixed, int fixed, string nm);
    int y;
    @(posedge clock);
    #1;
    i_x     = 8'(x);
    i_rst_n = rst;
    y = model_out(x);
    if (mvalid) begin
      exp_q.push_back(use_fixed ? fixed : y);
      name_q.push_back(nm);
    end
    if (rst) begin
      mx = '{0, 0, 0};
      my = '{0, 0};
      mvalid = 1'b1;
    end else begin
      mx[2] = mx[1]; mx[1] = mx[0]; mx[0] = x;
      my[1] = my[0]; my[0] = y;
    end
  endtask

  task automatic check_regs(string nm, int a, int b, int c, int d, int e);
    check({nm, "_xm1"}, int'(dut.r_xm1), a);
    check({nm, "_xm2"}, int'(dut.r_xm2), b);
    check({nm, "_xm3"}, int'(dut.r_xm3), c);
    check({nm, "_ym1"}, int'(dut.r_ym1), d);
    check({nm, "_ym2"}, int'(dut.r_ym2), e);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      int    e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, int'(o_y), e);
    end
  end

  initial begin
    int seq_x [6];
    int seq_y [6];
    int v;
    seq_x = '{1, 2, 3, 4, 1, 2};
    seq_y = '{1, 1, 2, 5, 4, 11};
    i_rst_n = 1'b1;
    i_x     = '0;

    drive(0, 1, 1, 0, "rst_out");
    drive(0, 1, 1, 0, "rst_out");
    drive(0, 0, 1, 0, "rst_release");
    check_regs("reset", 0, 0, 0, 0, 0);

    drive(0, 1, 1, 0, "seq_rst");
    for (int i = 0; i < 6; i++) begin
      drive(seq_x[i], 0, 1, seq_y[i], "seq1");
      if (i == 4) check_regs("after4", 4, 3, 2, 5, 2);
    end

    drive(0, 1, 0, 0, "neg_rst");
    drive(-1, 0, 1, -1, "neg_a");
    drive(0, 0, 1, 0, "neg_b");

    drive(0, 1, 0, 0, "wrap_rst");
    drive(127, 0, 1, 127, "wrap_a");
    drive(127, 0, 1, 63, "wrap_b");
    drive(127, 0, 1, -67, "wrap_c");

    drive(0, 1, 0, 0, "mid_rst0");
    for (int i = 0; i < 3; i++) drive(seq_x[i], 0, 1, seq_y[i], "mid_pre");
    drive(5, 1, 0, 0, "mid_rst");
    drive(seq_x[0], 0, 1, seq_y[0], "mid_post");
    check_regs("mid", 0, 0, 0, 0, 0);
    for (int i = 1; i < 3; i++) drive(seq_x[i], 0, 1, seq_y[i], "mid_post");

    drive(0, 1, 0, 0, "hold_rst");
    for (int i = 0; i < 5; i++) begin
      v = int'($urandom_range(0, 255)) - 128;
      drive(v, 1, 1, v, "hold_track");
    end
    check_regs("hold", 0, 0, 0, 0, 0);

    for (int i = 0; i < 1200; i++) begin
      v = int'($urandom_range(0, 255)) - 128;
      drive(v, ($urandom_range(0, 99) == 0), 0, 0, "random");
    end

    repeat (3) @(posedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
